// File: rtl/fw_wb_master.sv
// Wishbone classic-cycle initiator: queued command words become single bus reads/writes
// with retry and timeout handling, answered by one in-order response per command.
`timescale 1ns/1ps
module fw_wb_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_bte_o,
  output logic [2:0]  wb_cti_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [31:0] wb_dat_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int EW = 69;

  localparam logic [1:0] RSP_OK  = 2'b00;
  localparam logic [1:0] RSP_ERR = 2'b01;
  localparam logic [1:0] RSP_RTY = 2'b10;
  localparam logic [1:0] RSP_TMO = 2'b11;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_GAP = 2'd2, ST_RESP = 2'd3} state_t;

  logic [EW-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s, empty_s, push_s, pop_s;
  logic [EW-1:0] head_s;

  state_t        state_r, state_nx_s;
  logic          cyc_r, cyc_nx_s, we_r, we_nx_s;
  logic [31:0]   adr_r, adr_nx_s, dat_r, dat_nx_s;
  logic [3:0]    sel_r, sel_nx_s;
  logic [RW-1:0] retry_cnt_r, retry_nx_s;
  logic [TW-1:0] tmo_cnt_r, tmo_nx_s;
  logic          rsp_valid_r, rsp_valid_nx_s;
  logic [31:0]   rsp_dat_r, rsp_dat_nx_s;
  logic [1:0]    rsp_status_r, rsp_status_nx_s;

  assign full_s    = (count_r == (AW+1)'(FIFO_DEPTH));
  assign empty_s   = (count_r == (AW+1)'(0));
  assign push_s    = cmd_valid & ~full_s;
  assign head_s    = fifo_mem_r[rd_ptr_r];
  assign cmd_ready = ~full_s;
  assign busy      = ~empty_s | (state_r != ST_IDLE);

  assign wb_cyc_o   = cyc_r;
  assign wb_stb_o   = cyc_r;
  assign wb_adr_o   = adr_r;
  assign wb_dat_o   = dat_r;
  assign wb_sel_o   = sel_r;
  assign wb_we_o    = we_r;
  assign wb_bte_o   = 2'b00;
  assign wb_cti_o   = 3'b000;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_dat    = rsp_dat_r;
  assign rsp_status = rsp_status_r;

  // Command storage; contents need no reset because count_r gates every read.
  always_ff @(posedge wb_clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Next-state and next-register values for the bus sequencer.
  always_comb begin
    state_nx_s      = state_r;
    cyc_nx_s        = cyc_r;
    we_nx_s         = we_r;
    adr_nx_s        = adr_r;
    dat_nx_s        = dat_r;
    sel_nx_s        = sel_r;
    retry_nx_s      = retry_cnt_r;
    tmo_nx_s        = tmo_cnt_r;
    rsp_valid_nx_s  = rsp_valid_r;
    rsp_dat_nx_s    = rsp_dat_r;
    rsp_status_nx_s = rsp_status_r;
    pop_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          we_nx_s     = head_s[68];
          adr_nx_s    = head_s[67:36];
          dat_nx_s    = head_s[68] ? head_s[35:4] : 32'h0000_0000;
          sel_nx_s    = head_s[3:0];
          cyc_nx_s    = 1'b1;
          retry_nx_s  = RW'(0);
          tmo_nx_s    = TW'(0);
          state_nx_s  = ST_BUS;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (wb_err_i) begin
          cyc_nx_s        = 1'b0;
          rsp_valid_nx_s  = 1'b1;
          rsp_status_nx_s = RSP_ERR;
          rsp_dat_nx_s    = 32'h0000_0000;
          state_nx_s      = ST_RESP;
        end else if (wb_rty_i) begin
          cyc_nx_s = 1'b0;
          if (retry_cnt_r < RW'(MAX_RETRIES)) begin
            retry_nx_s = retry_cnt_r + RW'(1);
            tmo_nx_s   = TW'(0);
            state_nx_s = ST_GAP;
          end else begin
            rsp_valid_nx_s  = 1'b1;
            rsp_status_nx_s = RSP_RTY;
            rsp_dat_nx_s    = 32'h0000_0000;
            state_nx_s      = ST_RESP;
          end
        end else if (wb_ack_i) begin
          cyc_nx_s        = 1'b0;
          rsp_valid_nx_s  = 1'b1;
          rsp_status_nx_s = RSP_OK;
          rsp_dat_nx_s    = we_r ? 32'h0000_0000 : wb_dat_i;
          state_nx_s      = ST_RESP;
        end else if (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
          // Dropping here keeps cyc high for exactly TIMEOUT_CYCLES cycles.
          cyc_nx_s        = 1'b0;
          rsp_valid_nx_s  = 1'b1;
          rsp_status_nx_s = RSP_TMO;
          rsp_dat_nx_s    = 32'h0000_0000;
          state_nx_s      = ST_RESP;
        end else begin
          tmo_nx_s = tmo_cnt_r + TW'(1);
        end
      end
      ST_GAP: begin
        cyc_nx_s   = 1'b1;
        tmo_nx_s   = TW'(0);
        state_nx_s = ST_BUS;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx_s = 1'b0;
          state_nx_s     = ST_IDLE;
        end else begin
          state_nx_s     = ST_RESP;
        end
      end
      default: begin
        cyc_nx_s       = 1'b0;
        rsp_valid_nx_s = 1'b0;
        state_nx_s     = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and all registered bus/response outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r      <= ST_IDLE;
      cyc_r        <= 1'b0;
      we_r         <= 1'b0;
      adr_r        <= 32'h0000_0000;
      dat_r        <= 32'h0000_0000;
      sel_r        <= 4'h0;
      retry_cnt_r  <= RW'(0);
      tmo_cnt_r    <= TW'(0);
      rsp_valid_r  <= 1'b0;
      rsp_dat_r    <= 32'h0000_0000;
      rsp_status_r <= 2'b00;
    end else begin
      state_r      <= state_nx_s;
      cyc_r        <= cyc_nx_s;
      we_r         <= we_nx_s;
      adr_r        <= adr_nx_s;
      dat_r        <= dat_nx_s;
      sel_r        <= sel_nx_s;
      retry_cnt_r  <= retry_nx_s;
      tmo_cnt_r    <= tmo_nx_s;
      rsp_valid_r  <= rsp_valid_nx_s;
      rsp_dat_r    <= rsp_dat_nx_s;
      rsp_status_r <= rsp_status_nx_s;
    end
  end

endmodule
